// File: rtl/count_pkg.sv
// Shared definitions for the counter input front end: debounce filter state
// encoding and default timing constants.
package count_pkg;

   typedef enum logic [1:0] {
      S_LOW       = 2'd0,
      S_WAIT_HIGH = 2'd1,
      S_HIGH      = 2'd2,
      S_WAIT_LOW  = 2'd3
   } filt_state_t;

   localparam int DEF_SYNC_STAGES     = 2;
   localparam int DEF_DEBOUNCE_CYCLES = 16;

endpackage

// File: rtl/count_debounce_filter.sv
// Synchroniser chain plus debounce FSM for one raw asynchronous input.
// The FSM state is brought out so the parent and any checker can observe it.
module count_debounce_filter
   import count_pkg::*;
#(
   parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic        raw,
   output logic        stable,
   output logic        rise,
   output filt_state_t state
);

   localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync;
   logic [CNT_W-1:0]       cnt;

   assign sync = sync_q[SYNC_STAGES-1];

   // High on exactly the edge where the stable level is about to flip 0->1.
   assign rise = ~stable & sync & (cnt == CNT_MAX);

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         sync_q <= '0;
         stable <= 1'b0;
         cnt    <= '0;
         state  <= S_LOW;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
         if (sync == stable) begin
            cnt   <= '0;
            state <= stable ? S_HIGH : S_LOW;
         end else if (cnt == CNT_MAX) begin
            stable <= ~stable;
            cnt    <= '0;
            state  <= stable ? S_LOW : S_HIGH;
         end else begin
            cnt   <= cnt + 1'b1;
            state <= stable ? S_WAIT_LOW : S_WAIT_HIGH;
         end
      end
   end

endmodule

// File: rtl/count_input_conditioner.sv
// Front end for the dual-channel event counter: debounced button -> one-cycle
// En pulse, debounced switch -> Slt, frozen while a press is settling or held.
module count_input_conditioner
   import count_pkg::*;
#(
   parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic Clk,
   input  logic Reset_n,
   input  logic Btn_raw,
   input  logic Sw_raw,
   output logic En,
   output logic Slt,
   output logic Btn_level
);

   logic        btn_stable;
   logic        btn_rise;
   filt_state_t btn_state;
   logic        sw_stable;
   logic        sw_rise_unused;
   filt_state_t sw_state_unused;

   count_debounce_filter #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_btn_filter (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .raw     (Btn_raw),
      .stable  (btn_stable),
      .rise    (btn_rise),
      .state   (btn_state)
   );

   count_debounce_filter #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_sw_filter (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .raw     (Sw_raw),
      .stable  (sw_stable),
      .rise    (sw_rise_unused),
      .state   (sw_state_unused)
   );

   // Slt only follows the switch while the button is idle low, so the counter
   // always sees a settled channel select alongside En.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         En        <= 1'b0;
         Slt       <= 1'b0;
         Btn_level <= 1'b0;
      end else begin
         En        <= btn_rise;
         Btn_level <= btn_stable;
         if (btn_state == S_LOW) begin
            Slt <= sw_stable;
         end
      end
   end

endmodule

// File: tb/tb_count_input_conditioner.sv
// Directed bench for count_input_conditioner: table of press/release vectors
// plus hand-written sequences for bounce, repeat, Slt freeze and reset cases.
module tb_count_input_conditioner;

   localparam int LAT = 17;

   logic Clk = 1'b0;
   logic Reset_n = 1'b0;
   logic Btn_raw = 1'b0;
   logic Sw_raw = 1'b0;
   logic En;
   logic Slt;
   logic Btn_level;

   int checks = 0;
   int errors = 0;
   int edge_cnt = 0;
   int en_cnt = 0;
   bit slt_at_en = 1'b0;
   bit lvl_seen = 1'b0;
   logic [31:0] exp_q[$];

   typedef struct {
      string name;
      int    hi;
      int    lo;
      int    exp_en;
      bit    exp_lvl;
   } vec_t;

   vec_t vecs[4];

   count_input_conditioner dut (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .Btn_raw   (Btn_raw),
      .Sw_raw    (Sw_raw),
      .En        (En),
      .Slt       (Slt),
      .Btn_level (Btn_level)
   );

   // clock / reset
   initial forever #5 Clk = ~Clk;

   always @(posedge Clk) edge_cnt <= edge_cnt + 1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_cnt);
      end
   endtask

   // scoreboard: every En pulse must match the next expected edge
   always @(negedge Clk) begin
      if (Btn_level === 1'b1) lvl_seen = 1'b1;
      if (En === 1'b1) begin
         if (en_cnt == 0) slt_at_en = Slt;
         en_cnt++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_en: En high after edge %0d, expected no pulse", edge_cnt);
         end else begin
            check("en_edge", edge_cnt, int'(exp_q.pop_front()));
         end
      end
   end

   // driver tasks (all called at a negedge)
   task automatic cycles(input int n);
      repeat (n) @(negedge Clk);
   endtask

   task automatic press(output int k);
      Btn_raw = 1'b1;
      k = edge_cnt + 1;
   endtask

   task automatic do_reset();
      @(negedge Clk);
      Reset_n = 1'b0;
      Btn_raw = 1'b0;
      Sw_raw  = 1'b0;
      exp_q.delete();
      en_cnt    = 0;
      lvl_seen  = 1'b0;
      slt_at_en = 1'b0;
      cycles(3);
      Reset_n = 1'b1;
      cycles(2);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached at edge %0d, expected completion", edge_cnt);
      errors++;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int k2;

      vecs[0] = '{"glitch10",  10,  40, 0, 1'b0};
      vecs[1] = '{"short15",   15,  40, 0, 1'b0};
      vecs[2] = '{"exact16",   16,  40, 1, 1'b1};
      vecs[3] = '{"clean200", 200,  40, 1, 1'b1};

      // reset state
      cycles(2);
      check("reset_en", int'(En), 0);
      check("reset_slt", int'(Slt), 0);
      check("reset_lvl", int'(Btn_level), 0);

      // table: single press of hi cycles then release of lo cycles
      for (int i = 0; i < 4; i++) begin
         do_reset();
         press(k);
         if (vecs[i].exp_en > 0) exp_q.push_back(32'(k + LAT));
         cycles(vecs[i].hi);
         Btn_raw = 1'b0;
         cycles(vecs[i].lo);
         check({vecs[i].name, "_en_count"}, en_cnt, vecs[i].exp_en);
         check({vecs[i].name, "_lvl_seen"}, int'(lvl_seen), int'(vecs[i].exp_lvl));
         check({vecs[i].name, "_lvl_end"}, int'(Btn_level), 0);
         check({vecs[i].name, "_missing_en"}, exp_q.size(), 0);
      end

      // bounce 5 high / 3 low x4, then steady high
      do_reset();
      for (int i = 0; i < 4; i++) begin
         Btn_raw = 1'b1;
         cycles(5);
         Btn_raw = 1'b0;
         cycles(3);
      end
      press(k);
      exp_q.push_back(32'(k + LAT));
      cycles(100);
      Btn_raw = 1'b0;
      cycles(40);
      check("bounce_en_count", en_cnt, 1);
      check("bounce_missing_en", exp_q.size(), 0);

      // repeat presses with a full release
      do_reset();
      press(k);
      exp_q.push_back(32'(k + LAT));
      cycles(40);
      Btn_raw = 1'b0;
      cycles(40);
      press(k);
      exp_q.push_back(32'(k + LAT));
      cycles(40);
      Btn_raw = 1'b0;
      cycles(40);
      check("repeat_en_count", en_cnt, 2);

      // release too short to debounce
      do_reset();
      press(k);
      exp_q.push_back(32'(k + LAT));
      cycles(40);
      Btn_raw = 1'b0;
      cycles(10);
      Btn_raw = 1'b1;
      cycles(40);
      Btn_raw = 1'b0;
      cycles(40);
      check("short_release_en_count", en_cnt, 1);

      // Slt freeze across a press
      do_reset();
      Sw_raw = 1'b1;
      cycles(30);
      check("slt_follow_sw", int'(Slt), 1);
      press(k);
      exp_q.push_back(32'(k + LAT));
      cycles(30);
      check("slt_at_en_1", int'(slt_at_en), 1);
      Sw_raw = 1'b0;
      cycles(40);
      check("slt_frozen_held", int'(Slt), 1);
      Btn_raw = 1'b0;
      cycles(18);
      check("slt_frozen_release", int'(Slt), 1);
      cycles(1);
      check("slt_after_release", int'(Slt), 0);
      check("slt_en_count", en_cnt, 1);

      // switch flips on the edge the button enters S_WAIT_HIGH
      do_reset();
      Sw_raw = 1'b1;
      cycles(15);
      press(k);
      exp_q.push_back(32'(k + LAT));
      cycles(30);
      check("simul_en_count", en_cnt, 1);
      check("simul_slt_at_en", int'(slt_at_en), 0);
      check("simul_slt_held", int'(Slt), 0);
      Btn_raw = 1'b0;
      cycles(40);
      check("simul_slt_after", int'(Slt), 1);

      // asynchronous reset in the middle of the En cycle
      do_reset();
      Sw_raw = 1'b1;
      cycles(30);
      press(k);
      exp_q.push_back(32'(k + LAT));
      cycles(LAT + 1);
      check("pre_reset_en", int'(En), 1);
      check("pre_reset_slt", int'(Slt), 1);
      #2 Reset_n = 1'b0;
      #1;
      check("async_reset_en", int'(En), 0);
      check("async_reset_slt", int'(Slt), 0);
      check("async_reset_lvl", int'(Btn_level), 0);
      cycles(2);
      Reset_n = 1'b1;
      k2 = edge_cnt + 1;
      exp_q.push_back(32'(k2 + LAT));
      cycles(30);
      check("held_after_reset_lvl", int'(Btn_level), 1);
      #2 Reset_n = 1'b0;
      #1;
      check("async_reset_lvl_high", int'(Btn_level), 0);
      cycles(2);

      // reset in the middle of debouncing a held button
      do_reset();
      press(k);
      cycles(10);
      Reset_n = 1'b0;
      cycles(3);
      Reset_n = 1'b1;
      k2 = edge_cnt + 1;
      exp_q.push_back(32'(k2 + LAT));
      check("mid_reset_no_en", en_cnt, 0);
      cycles(40);
      check("mid_reset_en_count", en_cnt, 1);
      check("mid_reset_missing_en", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
